// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU-core constants used by the register file and its bus interface.
//   DATA_W_DEF / ADDR_W_DEF : default register width and register index width
//   ZERO_REG                : index of the hardwired-zero register
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/scoreboard_regfile_if.sv
// -----------------------------------------------------------------------------
// scoreboard_regfile_if
//   Bundles the decode/issue/writeback side of the scoreboarded register file.
//   master : pipeline side (drives read indices, writeback, reservations, flush)
//   slave  : register file side (returns read data, busy flags, full, error)
//   rd_addr  NUM_RD*ADDR_W  read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  NUM_RD*DATA_W  read data,    port i at [i*DATA_W +: DATA_W]
//   rd_busy  NUM_RD         source of port i still has an outstanding write
//   wr_en/wr_addr/wr_data   writeback strobe, index, data
//   rsv_en/rsv_addr         issue reserves rsv_addr as a pending destination
//   rsv_full                reservation counter of rsv_addr saturated
//   flush                   clear all pending reservations
//   wb_err                  sticky: writeback hit a non-reserved register
// -----------------------------------------------------------------------------
interface scoreboard_regfile_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_full;
  logic                     flush;
  logic                     wb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, rsv_full, wb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, rsv_full, wb_err
  );

endinterface

// File: rtl/rf_pend_counter.sv
// -----------------------------------------------------------------------------
// rf_pend_counter
//   Saturating up/down counter tracking outstanding writes to one register.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (dominates inc/dec)
//   inc, dec : count up / down; both together leave the count unchanged
//   cnt      : current count
//   is_zero  : cnt == 0
//   is_max   : cnt == 2**CNT_W-1
//   The count never wraps: inc at max and dec at zero are ignored.
// -----------------------------------------------------------------------------
module rf_pend_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_zero,
  output logic             is_max
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_max  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/scoreboard_regfile.sv
// -----------------------------------------------------------------------------
// scoreboard_regfile
//   Register file with NUM_RD combinational read ports, one write port with
//   write-through bypass, hardwired-zero register 0, and a per-register
//   pending-write scoreboard (issue reserves, writeback releases).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (clears data, counters, wb_err)
//   bus : scoreboard_regfile_if.slave, see the interface for signal meanings
// -----------------------------------------------------------------------------
module scoreboard_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  scoreboard_regfile_if.slave bus
);

  localparam int               NREGS    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  pend   [NREGS];
  logic [NREGS-1:0]  pend_zero;
  logic [NREGS-1:0]  pend_max;
  logic              wb_err_q;
  logic              wb_err_d;
  logic              wr_live;
  logic              rsv_full;

  assign wr_live = bus.wr_en && (bus.wr_addr != ZERO_IDX);

  // ---- register storage: write at posedge, index 0 never written ----
  always_comb begin
    regs_d = regs_q;
    if (wr_live) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // A writeback to a register with no reservation is flagged, unless the same
  // cycle flushes the scoreboard (the flush makes every reservation moot).
  always_comb begin
    wb_err_d = wb_err_q;
    if (wr_live && pend_zero[bus.wr_addr] && !bus.flush) begin
      wb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign bus.wb_err = wb_err_q;

  // ---- pending-write scoreboard ----
  // Register 0 is never tracked: it reads as idle and can never fill up.
  assign pend[0]      = '0;
  assign pend_zero[0] = 1'b1;
  assign pend_max[0]  = 1'b0;

  // A writeback in the same cycle frees a slot, so a saturated counter still
  // accepts the reservation (the two cancel).
  assign rsv_full = (bus.rsv_addr != ZERO_IDX) && pend_max[bus.rsv_addr] &&
                    !(bus.wr_en && (bus.wr_addr == bus.rsv_addr));
  assign bus.rsv_full = rsv_full;

  for (genvar r = 1; r < NREGS; r++) begin : g_pend
    logic inc;
    logic dec;

    assign inc = bus.rsv_en && (bus.rsv_addr == ADDR_W'(r)) && !rsv_full;
    assign dec = bus.wr_en && (bus.wr_addr == ADDR_W'(r)) && !pend_zero[r];

    rf_pend_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (bus.flush),
      .inc     (inc),
      .dec     (dec),
      .cnt     (pend[r]),
      .is_zero (pend_zero[r]),
      .is_max  (pend_max[r])
    );
  end

  // ---- combinational read ports ----
  // Busy reflects the count after this cycle's writeback: a register with one
  // outstanding write that is being written back now is already free.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              wr_hit;
    logic              byp;

    assign a      = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign wr_hit = bus.wr_en && (bus.wr_addr == a);
    // Bypass is suppressed in reset so reads return zero while rst is held.
    assign byp    = wr_hit && !rst;

    assign bus.rd_data[i*DATA_W +: DATA_W] = (a == ZERO_IDX) ? '0 :
                                             byp             ? bus.wr_data :
                                                               regs_q[a];
    assign bus.rd_busy[i] = !pend_zero[a] && !(wr_hit && (pend[a] == CNT_W'(1)));
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_regfile
//   Directed scenarios plus randomized traffic for scoreboard_regfile, checked
//   every cycle against an array-based behavioural model of the register file
//   and its reservation counts.
// -----------------------------------------------------------------------------
module tb_scoreboard_regfile;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NR    = 2;
  localparam int CW    = 2;
  localparam int NREGS = 16;
  localparam int PMAX  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scoreboard_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  scoreboard_regfile #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .CNT_W  (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  // behavioural model state
  int reg_m  [NREGS];
  int pend_m [NREGS];
  bit err_m;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int got_rd(input int p);
    return int'(bus.rd_data[p*DW +: DW]);
  endfunction

  function automatic int got_busy(input int p);
    return int'(bus.rd_busy[p]);
  endfunction

  // ---- model: expected combinational outputs ----
  function automatic int exp_rd(input int a);
    if (rst || a == 0) return 0;
    if (bus.wr_en && int'(bus.wr_addr) == a) return int'(bus.wr_data);
    return reg_m[a];
  endfunction

  function automatic int exp_busy(input int a);
    int after;
    after = pend_m[a];
    if (bus.wr_en && int'(bus.wr_addr) == a && pend_m[a] > 0) after = after - 1;
    return (after != 0) ? 1 : 0;
  endfunction

  function automatic int exp_full();
    int ra;
    ra = int'(bus.rsv_addr);
    if (ra == 0) return 0;
    if (bus.wr_en && int'(bus.wr_addr) == ra) return 0;
    return (pend_m[ra] == PMAX) ? 1 : 0;
  endfunction

  // ---- model: state update at a rising edge ----
  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      reg_m[r]  = 0;
      pend_m[r] = 0;
    end
    err_m = 1'b0;
  endtask

  task automatic model_edge();
    int wa;
    int ra;
    bit inc;
    bit dec;
    if (rst) return;
    wa  = int'(bus.wr_addr);
    ra  = int'(bus.rsv_addr);
    inc = bus.rsv_en && ra != 0 && exp_full() == 0 && !bus.flush;
    dec = bus.wr_en && wa != 0 && pend_m[wa] > 0;
    if (bus.wr_en && wa != 0) begin
      if (pend_m[wa] == 0 && !bus.flush) err_m = 1'b1;
      reg_m[wa] = int'(bus.wr_data);
    end
    if (bus.flush) begin
      for (int r = 0; r < NREGS; r++) pend_m[r] = 0;
    end else begin
      if (inc) pend_m[ra] = pend_m[ra] + 1;
      if (dec) pend_m[wa] = pend_m[wa] - 1;
    end
  endtask

  // ---- compare process: every cycle on the falling edge ----
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < NR; i++) begin
        check($sformatf("rd_data[%0d]", i), got_rd(i), exp_rd(int'(bus.rd_addr[i*AW +: AW])));
        check($sformatf("rd_busy[%0d]", i), got_busy(i), exp_busy(int'(bus.rd_addr[i*AW +: AW])));
      end
      check("rsv_full", int'(bus.rsv_full), exp_full());
      check("wb_err", int'(bus.wb_err), int'(err_m));
    end
  end

  // ---- stimulus helpers (inputs change 1 time unit after a rising edge) ----
  task automatic idle();
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = DW'(d);
  endtask

  task automatic rsv(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  task automatic rand_inputs();
    set_rd(0, $urandom_range(0, 7));
    set_rd(1, $urandom_range(0, 7));
    bus.wr_en    = 1'($urandom_range(0, 1));
    bus.wr_addr  = AW'($urandom_range(0, 7));
    bus.wr_data  = DW'($urandom);
    bus.rsv_en   = 1'($urandom_range(0, 1));
    bus.rsv_addr = AW'($urandom_range(0, 7));
    bus.flush    = ($urandom_range(0, 15) == 0);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    run = 1'b1;
    @(posedge clk);
    #1;
    check("reset_rd_data0", got_rd(0), 0);
    check("reset_wb_err", int'(bus.wb_err), 0);
    step();
    step();
    rst = 1'b0;

    // reserve r3, observe busy, writeback with bypass, then read the stored value
    idle(); rsv(3); step();
    idle(); set_rd(0, 3); #1;
    check("t2_busy_reserved", got_busy(0), 1);
    step();
    idle(); set_rd(0, 3); wr(3, 'hBEEF); #1;
    check("t2_bypass_data", got_rd(0), 'hBEEF);
    check("t2_busy_released", got_busy(0), 0);
    step();
    idle(); set_rd(0, 3); #1;
    check("t2_stored_data", got_rd(0), 'hBEEF);
    check("t2_pend_zero", got_busy(0), 0);
    step();

    // register 0: writes ignored, never reserved
    idle(); wr(0, 'hFFFF); rsv(0); #1;
    check("t4_rd_zero", got_rd(0), 0);
    check("t4_busy_zero", got_busy(0), 0);
    check("t4_rsv_full", int'(bus.rsv_full), 0);
    step();
    idle(); #1;
    check("t4_wb_err", int'(bus.wb_err), 0);
    step();

    // same-cycle reserve + writeback on r4 with one outstanding write
    idle(); rsv(4); step();
    idle(); rsv(4); wr(4, 'h4444); set_rd(0, 4); #1;
    check("t6_busy_same_cycle", got_busy(0), 0);
    check("t6_bypass", got_rd(0), 'h4444);
    step();
    idle(); set_rd(0, 4); #1;
    check("t6_pend_still_one", got_busy(0), 1);
    step();
    idle(); wr(4, 0); step();

    // flush with a concurrent writeback
    idle(); rsv(2); step();
    idle(); rsv(7); step();
    idle(); bus.flush = 1'b1; wr(2, 'h1234); rsv(9); step();
    idle(); set_rd(0, 2); set_rd(1, 7); #1;
    check("t5_data", got_rd(0), 'h1234);
    check("t5_busy_r2", got_busy(0), 0);
    check("t5_busy_r7", got_busy(1), 0);
    check("t5_wb_err", int'(bus.wb_err), 0);
    step();
    idle(); set_rd(0, 9); #1;
    check("t5_rsv_ignored", got_busy(0), 0);
    step();

    // saturation of r5, then drain and one extra writeback
    for (int k = 0; k < 3; k++) begin
      idle(); rsv(5); step();
    end
    idle(); rsv(5); #1;
    check("t3_rsv_full", int'(bus.rsv_full), 1);
    step();
    for (int k = 0; k < 3; k++) begin
      idle(); wr(5, 'h500 + k); set_rd(1, 5); #1;
      check($sformatf("t3_busy_wb%0d", k), got_busy(1), (k < 2) ? 1 : 0);
      step();
    end
    idle(); set_rd(1, 5); #1;
    check("t3_busy_after", got_busy(1), 0);
    check("t3_no_err_yet", int'(bus.wb_err), 0);
    step();
    idle(); wr(5, 'h5555); step();
    idle(); #1;
    check("t3_wb_err", int'(bus.wb_err), 1);
    step();

    // randomized traffic
    repeat (1500) begin
      rand_inputs();
      step();
    end

    // reset pulse mid-run, with a bypass-eligible write present
    rand_inputs();
    wr(3, 'hAAAA);
    set_rd(0, 3);
    set_rd(1, 2);
    rst = 1'b1;
    model_clear();
    #1;
    check("t1_rd0_zero", got_rd(0), 0);
    check("t1_rd1_zero", got_rd(1), 0);
    check("t1_busy0", got_busy(0), 0);
    check("t1_busy1", got_busy(1), 0);
    check("t1_wb_err", int'(bus.wb_err), 0);
    check("t1_rsv_full", int'(bus.rsv_full), 0);
    step();
    rst = 1'b0;
    idle();
    set_rd(0, 3);
    #1;
    check("t1_reg3_cleared", got_rd(0), 0);
    step();

    repeat (500) begin
      rand_inputs();
      step();
    end

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
